// File: rtl/hkr_bus_arbiter.sv
// Arbitrates the hkr_mips instruction and data buses onto one Avalon-style master port.
// One transfer at a time; ibus is forced a grant after STARVE_LIMIT dbus grants while it waits.
module hkr_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ibus_addr,
    input  logic [3:0]  ibus_byte_en,
    input  logic        ibus_read,
    input  logic        ibus_write,
    input  logic [31:0] ibus_write_data,
    output logic [31:0] ibus_read_data,
    output logic        ibus_stall,
    input  logic [31:0] dbus_addr,
    input  logic [3:0]  dbus_byte_en,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [31:0] dbus_write_data,
    output logic [31:0] dbus_read_data,
    output logic        dbus_stall,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wrdata,
    input  logic [31:0] mem_rddata,
    input  logic        mem_waitrequest
);

    typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_next;
    logic [3:0] starve_cnt;
    logic       ireq;
    logic       dreq;
    logic       force_i;

    assign ireq    = ibus_read | ibus_write;
    assign dreq    = dbus_read | dbus_write;
    assign force_i = ireq && (starve_cnt == LIMIT);

    // The bus just served is retiring in DONE_x, so only the other bus is considered there.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dreq && !force_i) begin
                    state_next = GRANT_D;
                end else if (ireq) begin
                    state_next = GRANT_I;
                end
            end
            GRANT_I: if (!mem_waitrequest) state_next = DONE_I;
            GRANT_D: if (!mem_waitrequest) state_next = DONE_D;
            DONE_I:  state_next = dreq ? GRANT_D : IDLE;
            DONE_D:  state_next = ireq ? GRANT_I : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ibus_stall = ireq && (state != DONE_I);
    assign dbus_stall = dreq && (state != DONE_D);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            starve_cnt     <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_wrdata     <= '0;
            ibus_read_data <= '0;
            dbus_read_data <= '0;
        end else begin
            state <= state_next;
            // Read+write together on one bus is issued as a write.
            if (state_next == GRANT_I && state != GRANT_I) begin
                mem_address    <= ibus_addr;
                mem_byteenable <= ibus_byte_en;
                mem_wrdata     <= ibus_write_data;
                mem_write      <= ibus_write;
                mem_read       <= ibus_read & ~ibus_write;
                starve_cnt     <= '0;
            end else if (state_next == GRANT_D && state != GRANT_D) begin
                mem_address    <= dbus_addr;
                mem_byteenable <= dbus_byte_en;
                mem_wrdata     <= dbus_write_data;
                mem_write      <= dbus_write;
                mem_read       <= dbus_read & ~dbus_write;
                if (ireq && starve_cnt < LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else if ((state == GRANT_I || state == GRANT_D) && !mem_waitrequest) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                if (mem_read) begin
                    if (state == GRANT_I) begin
                        ibus_read_data <= mem_rddata;
                    end else begin
                        dbus_read_data <= mem_rddata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hkr_bus_arbiter.sv
// Directed bench for hkr_bus_arbiter: stimulus queues expected master-port transfers,
// a negedge monitor pops and compares them as each transfer completes.
module tb_hkr_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ibus_addr = '0;
    logic [3:0]  ibus_byte_en = '0;
    logic        ibus_read = 1'b0;
    logic        ibus_write = 1'b0;
    logic [31:0] ibus_write_data = '0;
    logic [31:0] ibus_read_data;
    logic        ibus_stall;
    logic [31:0] dbus_addr = '0;
    logic [3:0]  dbus_byte_en = '0;
    logic        dbus_read = 1'b0;
    logic        dbus_write = 1'b0;
    logic [31:0] dbus_write_data = '0;
    logic [31:0] dbus_read_data;
    logic        dbus_stall;
    logic [31:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wrdata;
    logic [31:0] mem_rddata;
    logic        mem_waitrequest;

    int checks = 0;
    int errors = 0;
    int slave_wait = 0;
    int wcnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t exp_q[$];

    hkr_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_addr(ibus_addr), .ibus_byte_en(ibus_byte_en), .ibus_read(ibus_read),
        .ibus_write(ibus_write), .ibus_write_data(ibus_write_data),
        .ibus_read_data(ibus_read_data), .ibus_stall(ibus_stall),
        .dbus_addr(dbus_addr), .dbus_byte_en(dbus_byte_en), .dbus_read(dbus_read),
        .dbus_write(dbus_write), .dbus_write_data(dbus_write_data),
        .dbus_read_data(dbus_read_data), .dbus_stall(dbus_stall),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata),
        .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk = ~clk;

    // Slave: inserts slave_wait wait cycles per transfer; read data is ~address except the boot word.
    assign mem_waitrequest = (mem_read | mem_write) && (wcnt < slave_wait);
    assign mem_rddata = (mem_address == 32'h8000_0000) ? 32'h3C08_0001 : ~mem_address;

    always @(posedge clk) begin
        if ((mem_read | mem_write) && mem_waitrequest) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(negedge clk) begin : monitor
        xfer_t e;
        if (rst_n && (mem_read || mem_write) && !mem_waitrequest) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected actual addr=%h rd=%b wr=%b required none",
                         mem_address, mem_read, mem_write);
            end else begin
                e = exp_q.pop_front();
                if (mem_address !== e.addr || mem_byteenable !== e.be || mem_write !== e.wr ||
                    mem_read !== !e.wr || (e.wr && mem_wrdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL xfer actual addr=%h be=%b rd=%b wr=%b wdata=%h required addr=%h be=%b wr=%b wdata=%h",
                             mem_address, mem_byteenable, mem_read, mem_write, mem_wrdata,
                             e.addr, e.be, e.wr, e.wdata);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] addr, input logic [3:0] be, input logic wr,
                        input logic [31:0] wdata);
        xfer_t e;
        e.addr = addr; e.be = be; e.wr = wr; e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    // Core-side transaction: hold the request until stall drops, then retire it on the next edge.
    task automatic bus_op(input string tag, input bit is_d, input bit wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input int exp_lat, output int strobes);
        int lat;
        bit done;
        lat = 0; strobes = 0; done = 0;
        if (is_d) begin
            dbus_addr = addr; dbus_byte_en = be; dbus_write_data = wdata;
            dbus_write = wr; dbus_read = !wr;
        end else begin
            ibus_addr = addr; ibus_byte_en = be; ibus_write_data = wdata;
            ibus_write = wr; ibus_read = !wr;
        end
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_read || mem_write) strobes++;
            if (!(is_d ? dbus_stall : ibus_stall)) done = 1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_read_data"}, is_d ? dbus_read_data : ibus_read_data, exp_rd);
        @(posedge clk); #1;
        if (is_d) begin
            dbus_read = 1'b0; dbus_write = 1'b0;
        end else begin
            ibus_read = 1'b0; ibus_write = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1;
        int s2;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_byteenable", 32'(mem_byteenable), 32'd0);
        chk("rst_ibus_read_data", ibus_read_data, 32'd0);
        chk("rst_dbus_read_data", dbus_read_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle buses: no stalls, no strobes.
        repeat (3) begin
            @(negedge clk);
            chk("idle_stalls", {30'd0, ibus_stall, dbus_stall}, 32'd0);
            chk("idle_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        end
        @(posedge clk); #1;

        // ibus boot fetch with 4 wait cycles.
        slave_wait = 4;
        push(32'h8000_0000, 4'hF, 1'b0, 32'h0);
        bus_op("ifetch", 1'b0, 1'b0, 32'h8000_0000, 4'hF, 32'h0, 32'h3C08_0001, 7, s1);
        chk("ifetch_strobe_cycles", 32'(s1), 32'd5);
        @(negedge clk);
        chk("ifetch_data_held", ibus_read_data, 32'h3C08_0001);
        @(posedge clk); #1;

        // Starvation: ibus pending at each arbitration point while dbus reads back to back.
        slave_wait = 0;
        dbus_addr = 32'h8000_2000; dbus_byte_en = 4'hF; dbus_write_data = 32'h0; dbus_read = 1'b1;
        ibus_addr = 32'h8000_0040; ibus_byte_en = 4'hF; ibus_write_data = 32'h0;
        repeat (4) push(32'h8000_2000, 4'hF, 1'b0, 32'h0);
        push(32'h8000_0040, 4'hF, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            ibus_read = 1'b1; @(posedge clk); #1;
            ibus_read = 1'b0; @(posedge clk); #1;
            @(posedge clk); #1;
        end
        ibus_read = 1'b1; @(posedge clk); #1;
        @(posedge clk); #1;
        ibus_read = 1'b0; dbus_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("starve_dbus_read_data", dbus_read_data, 32'h7FFF_DFFF);
        chk("starve_ibus_read_data", ibus_read_data, 32'h7FFF_FFBF);
        chk("starve_queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;

        // Simultaneous requests: dbus first, ibus straight after DONE_D.
        push(32'h8000_1000, 4'b0011, 1'b1, 32'hDEAD_BEEF);
        push(32'h8000_0080, 4'hF, 1'b0, 32'h0);
        fork
            bus_op("both_d", 1'b1, 1'b1, 32'h8000_1000, 4'b0011, 32'hDEAD_BEEF, 32'h7FFF_DFFF, 3, s1);
            bus_op("both_i", 1'b0, 1'b0, 32'h8000_0080, 4'hF, 32'h0, 32'h7FFF_FF7F, 5, s2);
        join
        chk("both_queue_drained", 32'(exp_q.size()), 32'd0);

        // dbus read withdrawn mid-grant still completes and captures data.
        slave_wait = 2;
        push(32'h8000_3000, 4'hF, 1'b0, 32'h0);
        dbus_addr = 32'h8000_3000; dbus_byte_en = 4'hF; dbus_read = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dbus_read = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("flush_dbus_stall", 32'(dbus_stall), 32'd0);
        end
        chk("flush_dbus_read_data", dbus_read_data, 32'h7FFF_CFFF);
        @(posedge clk); #1;
        slave_wait = 0;
        push(32'h8000_0100, 4'hF, 1'b0, 32'h0);
        bus_op("after_flush", 1'b0, 1'b0, 32'h8000_0100, 4'hF, 32'h0, 32'h7FFF_FEFF, 3, s1);
        chk("flush_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset during a long dbus write grant abandons it.
        slave_wait = 8;
        dbus_addr = 32'h8000_4000; dbus_byte_en = 4'hF; dbus_write_data = 32'h1234_5678;
        dbus_write = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_mem_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0; dbus_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("midrst_mem_address", mem_address, 32'd0);
        chk("midrst_mem_wrdata", mem_wrdata, 32'd0);
        chk("midrst_ibus_read_data", ibus_read_data, 32'd0);
        chk("midrst_dbus_read_data", dbus_read_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        @(posedge clk); #1;

        // Fresh ibus write after reset: full 3-cycle latency, read data untouched.
        slave_wait = 0;
        push(32'h8000_5000, 4'b1100, 1'b1, 32'hCAFE_F00D);
        bus_op("post_rst_iwrite", 1'b0, 1'b1, 32'h8000_5000, 4'b1100, 32'hCAFE_F00D, 32'h0, 3, s1);
        repeat (2) @(posedge clk);
        chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hkr_bus_arbiter.md
Name: hkr_bus_arbiter

Overview:
- Shares one Avalon-style memory master port between the hkr_mips instruction bus (ibus) and data bus (dbus).
- Grants one requester at a time, latches its request, and holds it on the master port until mem_waitrequest drops.
- Returns read data through a registered output and drives ibus_stall/dbus_stall back to the core.
- Sits between hkr_mips and the single SRAM/ROM controller.

Parameters:
- STARVE_LIMIT, 4, consecutive dbus grants allowed while ibus is pending before ibus is forced a grant (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ibus_addr  in  32  instruction bus address
- ibus_byte_en  in  4  instruction bus byte enables
- ibus_read  in  1  instruction bus read request
- ibus_write  in  1  instruction bus write request
- ibus_write_data  in  32  instruction bus write data
- ibus_read_data  out  32  instruction bus read data (registered)
- ibus_stall  out  1  instruction bus stall to core
- dbus_addr  in  32  data bus address
- dbus_byte_en  in  4  data bus byte enables
- dbus_read  in  1  data bus read request
- dbus_write  in  1  data bus write request
- dbus_write_data  in  32  data bus write data
- dbus_read_data  out  32  data bus read data (registered)
- dbus_stall  out  1  data bus stall to core
- mem_address  out  32  master address
- mem_byteenable  out  4  master byte enables
- mem_read  out  1  master read strobe
- mem_write  out  1  master write strobe
- mem_wrdata  out  32  master write data
- mem_rddata  in  32  master read data, valid in the cycle mem_waitrequest=0
- mem_waitrequest  in  1  slave wait; transfer completes in the first granted cycle it is 0

Behaviour:
- Reset:
  - Synchronous, active-low; the only clock is clk.
  - While rst_n=0 at a clk edge: state<=IDLE, starve_cnt<=0, mem_read/mem_write<=0, mem_address/mem_byteenable/mem_wrdata<=0, ibus_read_data/dbus_read_data<=0.
  - Reset mid-transaction abandons the transfer; strobes are low from the first cycle after the reset edge.
- Request definitions: ireq = ibus_read|ibus_write; dreq = dbus_read|dbus_write. Read and write asserted together on one bus is illegal; treat it as a write.
- States: IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D.
- Arbitration, evaluated in IDLE:
  - dreq and not force_i -> GRANT_D.
  - else ireq -> GRANT_I.
  - else stay in IDLE.
  - force_i = ireq & (starve_cnt==STARVE_LIMIT).
- On entry to GRANT_x: latch addr, byte_en, write_data, read/write of bus x into the mem_* registers. mem_* remain constant for the whole grant.
- In GRANT_x with mem_waitrequest=0:
  - Deassert mem_read/mem_write at that edge.
  - If it was a read, capture mem_rddata into x_read_data.
  - Go to DONE_x.
- In GRANT_x with mem_waitrequest=1: hold.
- DONE_x lasts exactly one cycle; x_stall=0 in that cycle so the core advances. Next state:
  - From DONE_I: GRANT_D if dreq, else IDLE.
  - From DONE_D: GRANT_I if ireq, else IDLE.
  - The served bus's request in the DONE cycle is the retiring one and is never re-granted.
- Stall outputs (combinational): x_stall = xreq & (state != DONE_x). No stall is raised when the bus is idle.
- Read data: x_read_data holds its value until the next completed read on that bus. Writes do not modify it.
- starve_cnt (4-bit):
  - On entering GRANT_D with ireq=1: increment, saturating at STARVE_LIMIT.
  - On entering GRANT_I: clear.
- Request dropped while granted (flush): the transfer still completes on the master port; DONE_x still occurs and the read data is still captured. The core ignores it.
- Latency: minimum 3 cycles from request to stall release (IDLE, GRANT, DONE) with mem_waitrequest=0. Add one cycle per extra wait cycle. Back-to-back cross-bus grants skip IDLE.

Test Plan:
- ibus_read addr 0x80000000, slave waits 4 cycles, rddata 0x3C080001 -> mem_read high for 5 cycles; ibus_stall low for exactly one cycle; ibus_read_data=0x3C080001 thereafter.
- ireq and dreq raised in the same cycle (dbus_write addr 0x80001000, data 0xDEADBEEF, be 4'b0011) -> dbus granted first with mem_byteenable=0011; ibus granted directly after DONE_D with no IDLE cycle.
- dreq held continuously with ireq pending, STARVE_LIMIT=4 -> exactly 4 dbus grants, then ibus granted; starve_cnt returns to 0.
- rst_n=0 during GRANT_D with waitrequest=1 -> next cycle mem_read=mem_write=0, state IDLE, both read_data outputs 0.
- dbus_read dropped mid-grant -> transfer completes; dbus_read_data updated; dbus_stall stays 0; next ireq is granted normally.
- Idle buses -> ibus_stall=dbus_stall=0 and no mem strobes.
